// File: rtl/ntt_stream_ctrl.sv
// rtl/ntt_stream_ctrl.sv - NTT/INTT pipeline sequencer: input handshake, stage fifo_en windows, done pulse.
// Optional abort input enabled by NTT_CTRL_ABORT_EN.
module ntt_stream_ctrl #(
  parameter int NTT_STAGE_CNT = 7,
  parameter int MUL_STAGE_CNT = 4,
  parameter int N             = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mode,
  input  logic in_valid,
`ifdef NTT_CTRL_ABORT_EN
  input  logic abort,
`endif
  output logic in_ready,
  output logic fifo_en [NTT_STAGE_CNT],
  output logic out_valid,
  output logic busy,
  output logic mode_q,
  output logic done,
  output logic err
);

  localparam int BEATS = N / 2;

  function automatic int lat_f(input int i, input logic m);
    return MUL_STAGE_CNT + (m ? (1 << i) : (1 << (NTT_STAGE_CNT - 1 - i)));
  endfunction

  function automatic int start_f(input int i, input logic m);
    int s;
    s = 0;
    for (int j = 0; j < i; j++) s += lat_f(j, m);
    return s;
  endfunction

  // Total latency is mode independent: both modes sum the same set of powers of two.
  localparam int T  = BEATS + start_f(NTT_STAGE_CNT, 1'b0);
  localparam int CW = $clog2(T + 1);

  localparam logic [CW-1:0] K_FEED_LAST  = CW'(BEATS - 1);
  localparam logic [CW-1:0] K_DRAIN_LAST = CW'(T - 1);
  localparam logic [CW-1:0] K_OUT_FIRST  = CW'(T - BEATS);
  localparam logic [CW-1:0] K_DONE       = CW'(T);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IN,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_d, err_d;
  logic            abort_hit;
  logic            live;

`ifdef NTT_CTRL_ABORT_EN
  assign abort_hit = abort && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_IN;
          mode_d  = mode;
          err_d   = 1'b0;
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          state_d = (BEATS == 1) ? S_DRAIN : S_FEED;
          cnt_d   = CW'(1);
        end
      end
      S_FEED: begin
        // Pipeline cannot stall: a missing beat is only recorded, timing carries on.
        if (!in_valid) err_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == K_FEED_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == K_DRAIN_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort_hit) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign in_ready  = (state_q == S_WAIT_IN) || (state_q == S_FEED);
  assign live      = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign out_valid = live && (cnt_q >= K_OUT_FIRST) && (cnt_q < K_DONE);

  for (genvar g = 0; g < NTT_STAGE_CNT; g++) begin : g_stage
    localparam logic [CW-1:0] NTT_LO   = CW'(start_f(g, 1'b0));
    localparam logic [CW-1:0] NTT_SPAN = CW'(BEATS + lat_f(g, 1'b0));
    localparam logic [CW-1:0] INT_LO   = CW'(start_f(g, 1'b1));
    localparam logic [CW-1:0] INT_SPAN = CW'(BEATS + lat_f(g, 1'b1));

    logic [CW-1:0] off;
    logic          in_win;

    // Unsigned offset wraps far above any span when cnt is below the window start.
    assign off    = mode_q ? (cnt_q - INT_LO) : (cnt_q - NTT_LO);
    assign in_win = off < (mode_q ? INT_SPAN : NTT_SPAN);

    if (g == 0) begin : g_first
      assign fifo_en[g] = (live && in_win) || ((state_q == S_WAIT_IN) && in_valid);
    end else begin : g_rest
      assign fifo_en[g] = live && in_win;
    end
  end

endmodule

// File: tb/tb_ntt_stream_ctrl.sv
// tb/tb_ntt_stream_ctrl.sv - directed vector bench for ntt_stream_ctrl (default parameters).
module tb_ntt_stream_ctrl;

  localparam int NS    = 7;
  localparam int T     = 283;
  localparam int KMAX  = 286;

  localparam int SIG_OV = 7;
  localparam int SIG_DN = 8;
  localparam int SIG_BS = 9;
  localparam int SIG_IR = 10;
  localparam int SIG_ER = 11;
  localparam int SIG_MQ = 12;

  logic clk = 1'b0;
  logic rst, start, mode, in_valid;
`ifdef NTT_CTRL_ABORT_EN
  logic abort;
`endif
  logic in_ready, out_valid, busy, mode_q, done, err;
  logic fifo_en [NS];

  always #5 clk = ~clk;

  ntt_stream_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .in_valid  (in_valid),
`ifdef NTT_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .in_ready  (in_ready),
    .fifo_en   (fifo_en),
    .out_valid (out_valid),
    .busy      (busy),
    .mode_q    (mode_q),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    int   run;
    int   sig;
    int   k;
    logic exp;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] cap [3][KMAX];
  int          nvec  = 0;
  int          nfail = 0;
  int          ndone;
  string       sig_name [13] = '{"fifo_en0", "fifo_en1", "fifo_en2", "fifo_en3", "fifo_en4",
                                 "fifo_en5", "fifo_en6", "out_valid", "done", "busy",
                                 "in_ready", "err", "mode_q"};

  function automatic logic [12:0] snap();
    logic [12:0] v;
    for (int i = 0; i < NS; i++) v[i] = fifo_en[i];
    v[SIG_OV] = out_valid;
    v[SIG_DN] = done;
    v[SIG_BS] = busy;
    v[SIG_IR] = in_ready;
    v[SIG_ER] = err;
    v[SIG_MQ] = mode_q;
    return v;
  endfunction

  function automatic void add(input int run, input int sig, input int k, input logic exp);
    vec_t v;
    v.run = run;
    v.sig = sig;
    v.k   = k;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int k, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s k=%0d got %b expected %b", name, k, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < NS; i++) check($sformatf("%s_fifo_en%0d", tag, i), 0, fifo_en[i], 1'b0);
    check({tag, "_busy"}, 0, busy, 1'b0);
    check({tag, "_done"}, 0, done, 1'b0);
    check({tag, "_in_ready"}, 0, in_ready, 1'b0);
    check({tag, "_out_valid"}, 0, out_valid, 1'b0);
  endtask

  // One full sequence; k counts from the WAIT_IN cycle in which beat 0 is offered.
  task automatic run_seq(input int r, input logic m, input int drop);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = ~m;
    for (int k = 0; k < KMAX; k++) begin
      in_valid = (k < T) && (k != drop);
      start    = (r == 2) && (k == 50 || k == T || k == T + 1);
      @(negedge clk);
      cap[r][k] = snap();
      @(posedge clk); #1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b0;
`ifdef NTT_CTRL_ABORT_EN
    abort    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_err", 0, err, 1'b0);
    check("reset_mode_q", 0, mode_q, 1'b0);

    // run 0: NTT, in_valid held high
    add(0, 0, 0, 1);   add(0, 0, 195, 1); add(0, 0, 196, 0);
    add(0, 1, 67, 0);  add(0, 1, 68, 1);  add(0, 1, 231, 1); add(0, 1, 232, 0);
    add(0, 6, 149, 0); add(0, 6, 150, 1); add(0, 6, 282, 1); add(0, 6, 283, 0);
    add(0, SIG_OV, 154, 0); add(0, SIG_OV, 155, 1); add(0, SIG_OV, 282, 1); add(0, SIG_OV, 283, 0);
    add(0, SIG_IR, 0, 1);   add(0, SIG_IR, 127, 1); add(0, SIG_IR, 128, 0);
    add(0, SIG_DN, 282, 0); add(0, SIG_DN, 283, 1); add(0, SIG_DN, 284, 0);
    add(0, SIG_BS, 0, 1);   add(0, SIG_BS, 283, 1); add(0, SIG_BS, 284, 0);
    add(0, SIG_ER, 200, 0); add(0, SIG_MQ, 100, 0);
    // run 1: INTT
    add(1, 0, 132, 1); add(1, 0, 133, 0);
    add(1, 1, 4, 0);   add(1, 1, 5, 1);   add(1, 1, 138, 1); add(1, 1, 139, 0);
    add(1, 6, 86, 0);  add(1, 6, 87, 1);  add(1, 6, 282, 1); add(1, 6, 283, 0);
    add(1, SIG_OV, 154, 0); add(1, SIG_OV, 155, 1);
    add(1, SIG_DN, 282, 0); add(1, SIG_DN, 283, 1);
    add(1, SIG_MQ, 0, 1);   add(1, SIG_MQ, 200, 1); add(1, SIG_MQ, 283, 1);
    // run 2: NTT, beat dropped at k=10, stray starts at k=50 and in DONE, restart at k=284
    add(2, 0, 10, 1);
    add(2, SIG_ER, 10, 0);  add(2, SIG_ER, 11, 1);  add(2, SIG_ER, 100, 1); add(2, SIG_ER, 284, 1);
    add(2, 0, 195, 1); add(2, 0, 196, 0); add(2, 6, 150, 1); add(2, 6, 283, 0);
    add(2, SIG_MQ, 100, 0); add(2, SIG_BS, 51, 1);
    add(2, SIG_DN, 283, 1); add(2, SIG_BS, 284, 0);
    add(2, SIG_BS, 285, 1); add(2, SIG_ER, 285, 0); add(2, SIG_MQ, 285, 1);
    add(2, SIG_IR, 285, 1); add(2, 0, 285, 0);

    run_seq(0, 1'b0, -1);
    run_seq(1, 1'b1, -1);
    run_seq(2, 1'b0, 10);

    foreach (vecs[i])
      check($sformatf("run%0d_%s", vecs[i].run, sig_name[vecs[i].sig]), vecs[i].k,
            cap[vecs[i].run][vecs[i].k][vecs[i].sig], vecs[i].exp);

    // Reset in the middle of an INTT sequence
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b1;
    repeat (200) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    check("midrst_err", 0, err, 1'b0);
    check("midrst_mode_q", 0, mode_q, 1'b0);
    ndone = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_int("midrst_done_count", ndone, 0);
    in_valid = 1'b0;

`ifdef NTT_CTRL_ABORT_EN
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_valid = (k != 10);
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    check("abort_err_held", 0, err, 1'b1);
    check("abort_mode_q_held", 0, mode_q, 1'b0);
    ndone = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_int("abort_done_count", ndone, 0);
    in_valid = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
